// File: rtl/axis_fxp_div.sv
// axis_fxp_div: AXI-Stream fixed-point divider (radix-2 restoring, one quotient bit per clock).
// Define AXIS_FXP_DIV_ROUND_EN to round half away from zero using one guard bit.
module axis_fxp_div #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 32,
    parameter int FRAC_W     = 16,
    parameter int SIGNED     = 0,
    localparam int DOUT_W    = DIVIDEND_W + FRAC_W
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_axis_dividend_tvalid,
    output logic                  s_axis_dividend_tready,
    input  logic [DIVIDEND_W-1:0] s_axis_dividend_tdata,
    input  logic                  s_axis_divisor_tvalid,
    output logic                  s_axis_divisor_tready,
    input  logic [DIVISOR_W-1:0]  s_axis_divisor_tdata,
    output logic                  m_axis_dout_tvalid,
    input  logic                  m_axis_dout_tready,
    output logic [DOUT_W-1:0]     m_axis_dout_tdata,
    output logic                  m_axis_dout_tuser
);

`ifdef AXIS_FXP_DIV_ROUND_EN
    localparam int ITER = DOUT_W + 1;
`else
    localparam int ITER = DOUT_W;
`endif
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int PAD_W = ITER - DIVIDEND_W;

    localparam logic [DOUT_W-1:0] ALL_ONES = {DOUT_W{1'b1}};
    localparam logic [DOUT_W-1:0] MAX_POS  = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic [DOUT_W-1:0] MIN_NEG  = {1'b1, {(DOUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   a_held_q, b_held_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DOUT_W-1:0]      dout_q;
    logic                   user_q;

    logic [DIVIDEND_W-1:0]  a_q;
    logic [DIVISOR_W-1:0]   b_q;
    logic [DIVISOR_W-1:0]   den_q;
    logic [DIVISOR_W-1:0]   rem_q;
    logic [ITER-1:0]        num_q;
    logic                   neg_q;

    logic                   a_fire, b_fire, dout_fire;
    logic                   b_zero, last_iter;
    logic                   a_neg, b_neg;
    logic [DIVIDEND_W-1:0]  a_mag;
    logic [DIVISOR_W-1:0]   b_mag;
    logic [DIVISOR_W:0]     trial;
    logic                   ge;
    logic [DIVISOR_W-1:0]   rem_d;
    logic [ITER-1:0]        quo_d;

    // Drops the guard bit, rounding the magnitude half away from zero when enabled.
    function automatic logic [DOUT_W:0] round_mag(input logic [ITER-1:0] q);
`ifdef AXIS_FXP_DIV_ROUND_EN
        return {1'b0, q[ITER-1:1]} + {{DOUT_W{1'b0}}, q[0]};
`else
        return {1'b0, q};
`endif
    endfunction

    function automatic logic [DOUT_W-1:0] saturate(input logic [DOUT_W:0] mag, input logic neg);
        logic signed [DOUT_W-1:0] res;
        if (SIGNED == 0)
            res = mag[DOUT_W] ? ALL_ONES : mag[DOUT_W-1:0];
        else if (neg)
            res = (mag > {1'b0, MIN_NEG}) ? MIN_NEG : -mag[DOUT_W-1:0];
        else
            res = (mag > {1'b0, MAX_POS}) ? MAX_POS : mag[DOUT_W-1:0];
        return res;
    endfunction

    function automatic logic [DOUT_W-1:0] div_zero_value(input logic dividend_neg);
        if (SIGNED == 0)
            return ALL_ONES;
        return dividend_neg ? MIN_NEG : MAX_POS;
    endfunction

    assign a_fire    = s_axis_dividend_tvalid && s_axis_dividend_tready;
    assign b_fire    = s_axis_divisor_tvalid && s_axis_divisor_tready;
    assign dout_fire = m_axis_dout_tvalid && m_axis_dout_tready;
    assign b_zero    = (b_q == '0);
    assign last_iter = (cnt_q == CNT_W'(ITER));

    assign a_neg = (SIGNED != 0) && a_q[DIVIDEND_W-1];
    assign b_neg = (SIGNED != 0) && b_q[DIVISOR_W-1];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;

    // Restoring step: the numerator shifts out of num_q while quotient bits shift in.
    always_comb begin
        trial = {rem_q, num_q[ITER-1]};
        ge    = (trial >= {1'b0, den_q});
        rem_d = ge ? DIVISOR_W'(trial - {1'b0, den_q}) : trial[DIVISOR_W-1:0];
        quo_d = {num_q[ITER-2:0], ge};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (a_held_q && b_held_q) state_d = CALC;
            CALC:    if ((cnt_q == '0 && b_zero) || last_iter) state_d = DONE;
            DONE:    if (m_axis_dout_tready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_axis_dividend_tready = 1'b0;
        s_axis_divisor_tready  = 1'b0;
        m_axis_dout_tvalid     = (state_q == DONE);
        m_axis_dout_tdata      = dout_q;
        m_axis_dout_tuser      = user_q;
        if (aresetn && state_q == IDLE) begin
            s_axis_dividend_tready = !a_held_q;
            s_axis_divisor_tready  = !b_held_q;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            a_held_q <= 1'b0;
            b_held_q <= 1'b0;
            cnt_q    <= '0;
            dout_q   <= '0;
            user_q   <= 1'b0;
        end else begin
            if (a_fire)
                a_held_q <= 1'b1;
            if (b_fire)
                b_held_q <= 1'b1;
            if (dout_fire) begin
                a_held_q <= 1'b0;
                b_held_q <= 1'b0;
            end
            case (state_q)
                IDLE: cnt_q <= '0;
                CALC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == '0 && b_zero) begin
                        dout_q <= div_zero_value(a_neg);
                        user_q <= 1'b1;
                    end else if (last_iter) begin
                        dout_q <= saturate(round_mag(quo_d), neg_q);
                        user_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand capture, magnitude conversion on the first CALC cycle, then iteration.
    always_ff @(posedge aclk) begin
        if (a_fire)
            a_q <= s_axis_dividend_tdata;
        if (b_fire)
            b_q <= s_axis_divisor_tdata;
        if (state_q == CALC) begin
            if (cnt_q == '0) begin
                num_q <= {a_mag, {PAD_W{1'b0}}};
                rem_q <= '0;
                den_q <= b_mag;
                neg_q <= a_neg ^ b_neg;
            end else begin
                num_q <= quo_d;
                rem_q <= rem_d;
            end
        end
    end

endmodule

// File: tb/tb_axis_fxp_div.sv
// tb_axis_fxp_div: directed and random checks of axis_fxp_div against an arithmetic reference,
// one unsigned and one signed instance at default widths.
module tb_axis_fxp_div;

`ifdef AXIS_FXP_DIV_ROUND_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif
    localparam int ITER = 48 + G;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_vld [2];
    logic        a_rdy [2];
    logic [31:0] a_dat [2];
    logic        b_vld [2];
    logic        b_rdy [2];
    logic [31:0] b_dat [2];
    logic        o_vld [2];
    logic        o_rdy [2];
    logic [47:0] o_dat [2];
    logic        o_usr [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axis_fxp_div #(.SIGNED(0)) u_dut_u (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_dividend_tvalid(a_vld[0]), .s_axis_dividend_tready(a_rdy[0]), .s_axis_dividend_tdata(a_dat[0]),
        .s_axis_divisor_tvalid(b_vld[0]),  .s_axis_divisor_tready(b_rdy[0]),  .s_axis_divisor_tdata(b_dat[0]),
        .m_axis_dout_tvalid(o_vld[0]), .m_axis_dout_tready(o_rdy[0]),
        .m_axis_dout_tdata(o_dat[0]),  .m_axis_dout_tuser(o_usr[0])
    );

    axis_fxp_div #(.SIGNED(1)) u_dut_s (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_dividend_tvalid(a_vld[1]), .s_axis_dividend_tready(a_rdy[1]), .s_axis_dividend_tdata(a_dat[1]),
        .s_axis_divisor_tvalid(b_vld[1]),  .s_axis_divisor_tready(b_rdy[1]),  .s_axis_divisor_tdata(b_dat[1]),
        .m_axis_dout_tvalid(o_vld[1]), .m_axis_dout_tready(o_rdy[1]),
        .m_axis_dout_tdata(o_dat[1]),  .m_axis_dout_tuser(o_usr[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Q32.16 quotient from plain integer division on magnitudes.
    function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [47:0] q, output logic z);
        logic [63:0] ma, mb, qq;
        bit neg;
        z   = (b == 32'h0);
        neg = sgn && (a[31] ^ b[31]);
        ma  = (sgn && a[31]) ? 64'h1_0000_0000 - {32'h0, a} : {32'h0, a};
        mb  = (sgn && b[31]) ? 64'h1_0000_0000 - {32'h0, b} : {32'h0, b};
        if (z) begin
            if (!sgn)
                q = 48'hFFFF_FFFF_FFFF;
            else
                q = a[31] ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF;
            return;
        end
        qq = (ma << (16 + G)) / mb;
        if (G == 1)
            qq = (qq + 64'd1) >> 1;
        if (!sgn)
            q = (qq > 64'hFFFF_FFFF_FFFF) ? 48'hFFFF_FFFF_FFFF : qq[47:0];
        else if (!neg)
            q = (qq > 64'h7FFF_FFFF_FFFF) ? 48'h7FFF_FFFF_FFFF : qq[47:0];
        else
            q = (qq > 64'h8000_0000_0000) ? 48'h8000_0000_0000 : 48'(64'd0 - qq);
    endfunction

    task automatic do_div(input int k, input logic [31:0] a, input logic [31:0] b,
                          input int gap, input int stall, input string tag,
                          output logic [47:0] got);
        logic [47:0] exp_q;
        logic        exp_z;
        int          lat;
        ref_div(k == 1, a, b, exp_q, exp_z);
        chk({tag, ":rdy_idle"}, {62'd0, a_rdy[k], b_rdy[k]}, 64'd3);
        a_vld[k] = 1'b1;
        a_dat[k] = a;
        if (gap > 0) begin
            tick();
            a_dat[k] = ~a;
            chk({tag, ":a_rdy_drop"}, a_rdy[k], 0);
            for (int i = 1; i < gap; i++)
                tick();
            chk({tag, ":no_start"}, o_vld[k], 0);
            chk({tag, ":b_rdy_wait"}, b_rdy[k], 1);
        end
        b_vld[k] = 1'b1;
        b_dat[k] = b;
        tick();
        a_vld[k] = 1'b0;
        b_vld[k] = 1'b0;
        chk({tag, ":rdy_busy"}, {62'd0, a_rdy[k], b_rdy[k]}, 64'd0);
        lat = 0;
        for (int n = 1; n <= ITER + 20; n++) begin
            tick();
            if (o_vld[k]) begin
                lat = n;
                break;
            end
        end
        chk({tag, ":latency"}, lat, exp_z ? 2 : ITER + 2);
        chk({tag, ":tdata"}, o_dat[k], exp_q);
        chk({tag, ":tuser"}, o_usr[k], exp_z);
        got = o_dat[k];
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, ":stall_vld"}, o_vld[k], 1);
            chk({tag, ":stall_data"}, o_dat[k], exp_q);
            chk({tag, ":stall_rdy"}, {62'd0, a_rdy[k], b_rdy[k]}, 64'd0);
        end
        o_rdy[k] = 1'b1;
        tick();
        o_rdy[k] = 1'b0;
        chk({tag, ":vld_clear"}, o_vld[k], 0);
        chk({tag, ":rdy_back"}, {62'd0, a_rdy[k], b_rdy[k]}, 64'd3);
    endtask

    initial begin
        logic [47:0] got;
        logic        seen;
        logic [31:0] ra, rb;
        for (int k = 0; k < 2; k++) begin
            a_vld[k] = 1'b0; a_dat[k] = '0;
            b_vld[k] = 1'b0; b_dat[k] = '0;
            o_rdy[k] = 1'b0;
        end

        repeat (3) tick();
        chk("reset_vld", o_vld[0], 0);
        chk("reset_data", o_dat[0], 0);
        chk("reset_user", o_usr[0], 0);
        chk("reset_rdy", {60'd0, a_rdy[0], b_rdy[0], a_rdy[1], b_rdy[1]}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("release_rdy", {60'd0, a_rdy[0], b_rdy[0], a_rdy[1], b_rdy[1]}, 64'hF);

        do_div(0, 32'd910336, 32'd909312, 0, 0, "ref_same", got);
        chk("ref_same_const", got, (G == 1) ? 48'd65610 : 48'd65609);
        do_div(1, -32'sd7, 32'd2, 0, 0, "sgn_m7_2", got);
        chk("sgn_m7_2_const", got, 48'hFFFF_FFFC_8000);
        do_div(0, 32'd5, 32'd0, 0, 0, "dz_u", got);
        chk("dz_u_const", got, 48'hFFFF_FFFF_FFFF);
        do_div(1, 32'd5, 32'd0, 0, 0, "dz_s", got);
        chk("dz_s_const", got, 48'h7FFF_FFFF_FFFF);
        do_div(1, -32'sd5, 32'd0, 0, 0, "dz_s_neg", got);
        do_div(0, 32'd910336, 32'd909312, 5, 0, "ref_gap", got);
        chk("ref_gap_const", got, (G == 1) ? 48'd65610 : 48'd65609);
        do_div(0, 32'd1000, 32'd3, 0, 10, "stall", got);
        do_div(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "sat_minneg", got);
        chk("sat_minneg_const", got, 48'h7FFF_FFFF_FFFF);

        a_vld[0] = 1'b1; a_dat[0] = 32'hDEAD_BEEF;
        b_vld[0] = 1'b1; b_dat[0] = 32'd12345;
        tick();
        a_vld[0] = 1'b0; b_vld[0] = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_vld", o_vld[0], 0);
        chk("abort_rdy", {62'd0, a_rdy[0], b_rdy[0]}, 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("abort_release_rdy", {62'd0, a_rdy[0], b_rdy[0]}, 64'd3);
        seen = 1'b0;
        for (int i = 0; i < ITER + 10; i++) begin
            tick();
            seen = seen | o_vld[0];
        end
        chk("abort_no_result", seen, 0);
        do_div(0, 32'd100, 32'd4, 0, 0, "post_reset", got);
        chk("post_reset_const", got, 48'h19_0000);

        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 2; k++) begin
                ra = $urandom;
                rb = $urandom >> $urandom_range(0, 31);
                do_div(k, ra, rb, $urandom_range(0, 3), $urandom_range(0, 2),
                       (k == 0) ? "rand_u" : "rand_s", got);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_fxp_div.md
AXIS_FXP_DIV -- requirements
Module: axis_fxp_div

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 32, dividend width in bits.
REQ-002 SHALL have parameter DIVISOR_W, default 32, divisor width in bits.
REQ-003 SHALL have parameter FRAC_W, default 16, fractional quotient bits; derived DOUT_W = DIVIDEND_W+FRAC_W (48 at defaults).
REQ-004 SHALL have parameter SIGNED, default 0, 1 = two's-complement operands and quotient.
REQ-005 SHALL have port aclk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port s_axis_dividend_tvalid / s_axis_dividend_tready / s_axis_dividend_tdata, in/out/in, 1/1/DIVIDEND_W, dividend channel.
REQ-008 SHALL have port s_axis_divisor_tvalid / s_axis_divisor_tready / s_axis_divisor_tdata, in/out/in, 1/1/DIVISOR_W, divisor channel.
REQ-009 SHALL have port m_axis_dout_tvalid / m_axis_dout_tready / m_axis_dout_tdata, out/in/out, 1/1/DOUT_W, quotient in Q(DIVIDEND_W).(FRAC_W).
REQ-010 SHALL have port m_axis_dout_tuser, output, 1, divide-by-zero flag qualified by m_axis_dout_tvalid.

Function
REQ-011 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; one division in flight.
REQ-012 SHALL capture each operand independently in IDLE: channel tready = IDLE and that operand not yet held; transfer on tvalid&&tready.
REQ-013 SHALL leave IDLE for CALC on the clock after both operands are held, whether they arrived on the same or different cycles.
REQ-014 SHALL in CALC's first cycle convert operands to magnitudes (SIGNED=1) and record result sign = XOR of operand signs.
REQ-015 SHALL perform radix-2 restoring division on {|dividend|, FRAC_W zeros} by |divisor|, one quotient bit per clock, ITER = DOUT_W iterations (DOUT_W+1 with rounding, REQ-027).
REQ-016 SHALL assert m_axis_dout_tvalid exactly ITER+2 clocks after the edge completing the second operand handshake.
REQ-017 SHALL hold m_axis_dout_tdata/tuser/tvalid stable in DONE until m_axis_dout_tready=1; return to IDLE on the following edge.
REQ-018 SHALL deassert both s_axis tready from the capture of the second operand until return to IDLE.
REQ-019 SHALL truncate magnitude toward zero without rounding, then apply sign (two's complement negate) when SIGNED=1.
REQ-020 SHALL on divisor==0 skip iteration, go to DONE next clock, tuser=1, tdata = all-ones (SIGNED=0) or max positive / min negative by dividend sign (SIGNED=1; dividend 0 gives max positive).
REQ-021 SHALL saturate SIGNED=1 results exceeding DOUT_W range (e.g. min-negative / -1) to max positive, tuser=0.
REQ-022 SHALL ignore tvalid on an already-held channel; a new operand on that channel waits for next IDLE.

Reset
REQ-023 SHALL on aresetn=0 asynchronously force FSM=IDLE, operand-held flags=0, m_axis_dout_tvalid=0, m_axis_dout_tdata=0, m_axis_dout_tuser=0.
REQ-024 SHALL drive both s_axis tready=0 while aresetn=0 and 1 in the first clock after release.
REQ-025 SHALL abort any in-flight division on reset with no output produced after release.

Configuration
REQ-026 SHALL use macro AXIS_FXP_DIV_ROUND_EN to select rounding.
REQ-027 SHALL with AXIS_FXP_DIV_ROUND_EN defined compute one guard bit (ITER=DOUT_W+1) and round magnitude half away from zero, saturating on carry-out; without it ITER=DOUT_W, truncation per REQ-019.

Verification
REQ-028 SHALL check defaults, 910336/909312, both valid same cycle: tdata=65609 (0x10049) truncating, 65610 with AXIS_FXP_DIV_ROUND_EN; tvalid at ITER+2 clocks.
REQ-029 SHALL check SIGNED=1, dividend -7, divisor 2: tdata=-229376 (0xFFFFFFFC8000), tuser=0.
REQ-030 SHALL check divisor 0, dividend 5: SIGNED=0 tdata=0xFFFFFFFFFFFF, SIGNED=1 tdata=0x7FFFFFFFFFFF, tuser=1, tvalid two clocks after handshake.
REQ-031 SHALL check dividend presented 5 cycles before divisor: dividend tready drops after capture, computation starts only after divisor handshake, result per REQ-028.
REQ-032 SHALL check m_axis_dout_tready held 0 for 10 cycles after tvalid: tdata stable, both s tready=0, next operands accepted after tready pulse.
REQ-033 SHALL check aresetn pulsed low mid-CALC: tvalid=0 immediately, no result emitted, next division 100/4 yields 25<<16 = 0x190000.
